// File: rtl/mul_pkg.sv
// Shared arithmetic-datapath constants and the multiplier FSM state type.
// The default width is common with the divider so round-trip pairs line up.
package mul_pkg;

  localparam int unsigned MulWidth    = 8;
  localparam int unsigned MulCntWidth = $clog2(MulWidth);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally adds the multiplicand, shifted by the
// current bit position, into the double-width accumulator.
module mul_step
  import mul_pkg::*;
#(
  parameter int unsigned Width = MulWidth,
  parameter int unsigned CntW  = MulCntWidth
) (
  input  logic [2*Width-1:0] acc_i,
  input  logic [Width-1:0]   mcand_i,
  input  logic [CntW-1:0]    shamt_i,
  input  logic               add_en_i,
  output logic [2*Width-1:0] acc_o
);

  logic [2*Width-1:0] addend;

  always_comb begin
    addend = {{Width{1'b0}}, mcand_i} << shamt_i;
    acc_o  = add_en_i ? (acc_i + addend) : acc_i;
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiply-accumulate: out = in1 * in2 + in3, one
// multiplier bit per clock, with a start/busy/done handshake.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned Width = MulWidth
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [Width-1:0]   in1_i,
  input  logic [Width-1:0]   in2_i,
  input  logic [Width-1:0]   in3_i,
  output logic [2*Width-1:0] out_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;
  localparam int unsigned AccW = 2 * Width;

  mul_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] mplier_q, mplier_d;
  logic [Width-1:0] mcand_q, mcand_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] out_q, out_d;
  logic            ovf_q, ovf_d;
  logic [AccW-1:0] step_acc;

  mul_step #(
    .Width (Width),
    .CntW  (CntW)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .shamt_i  (cnt_q),
    .add_en_i (mplier_q[cnt_q]),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          cnt_d    = '0;
          mplier_d = in1_i;
          mcand_d  = in2_i;
          acc_d    = {{Width{1'b0}}, in3_i};
        end
      end
      StRun: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        // Final iteration: the result goes straight from the adder to out.
        if (cnt_q == CntW'(Width - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
          out_d   = step_acc;
          ovf_d   = |step_acc[AccW-1:Width];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_o  = out_q;
  assign ovf_o  = ovf_q;
  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_mul_seq.sv
// Randomized self-checking bench for mul_seq against an arithmetic reference.
module tb_mul_seq;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   in1, in2, in3;
  logic [2*W-1:0] out;
  logic           busy, done, ovf;

  int n_vec = 0;
  int n_err = 0;

  mul_seq #(.Width(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .in1_i   (in1),
    .in2_i   (in2),
    .in3_i   (in3),
    .out_o   (out),
    .busy_o  (busy),
    .done_o  (done),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mac(input int unsigned a, b, c);
    int unsigned r;
    r = a * b + c;
    return r[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op, scramble inputs after acceptance, and check timing and result.
  task automatic run_op(input string tag, input logic [W-1:0] a, b, c,
                        input logic [2*W-1:0] exp);
    int cycles;
    int busy_cnt;
    logic overlap;
    in1 = a; in2 = b; in3 = c; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0; busy_cnt = 0; overlap = 1'b0;
    while (!done && cycles <= 20) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
      start = ($urandom_range(0, 1) == 1);
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, ".latency"}, cycles, W);
    check({tag, ".busy_cycles"}, busy_cnt, W);
    check({tag, ".overlap"}, {31'b0, overlap | (busy & done)}, 0);
    check({tag, ".out"}, {16'b0, out}, {16'b0, exp});
    check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, exp[2*W-1:W] != 0});
    tick();
    check({tag, ".done_pulse"}, {31'b0, done}, 0);
    check({tag, ".hold"}, {16'b0, out}, {16'b0, exp});
  endtask

  logic [W-1:0] ha [0:29];
  logic [W-1:0] hb [0:29];
  logic [W-1:0] hc [0:29];

  initial begin
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; in3 = '0;
    tick();
    tick();
    check("reset.out", {16'b0, out}, 0);
    check("reset.ovf", {31'b0, ovf}, 0);
    check("reset.busy", {31'b0, busy}, 0);
    check("reset.done", {31'b0, done}, 0);
    rst = 1'b0;
    tick();

    run_op("basic", 8'd13, 8'd11, 8'd5, ref_mac(13, 11, 5));
    run_op("max", 8'd255, 8'd255, 8'd255, ref_mac(255, 255, 255));
    check("max.const", {16'b0, out}, 32'h0000_FF00);
    run_op("zero_in1", 8'd0, 8'd200, 8'd7, 16'd7);
    run_op("zero_in2", 8'd200, 8'd0, 8'd7, 16'd7);
    run_op("max_again", 8'd255, 8'd255, 8'd255, 16'hFF00);

    // Abort during the 4th RUN cycle.
    in1 = 8'd13; in2 = 8'd11; in3 = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.out", {16'b0, out}, 0);
    check("abort.ovf", {31'b0, ovf}, 0);
    check("abort.busy", {31'b0, busy}, 0);
    check("abort.done", {31'b0, done}, 0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (12) begin
        tick();
        seen = seen | done | busy;
      end
      check("abort.quiet", {31'b0, seen}, 0);
    end
    run_op("after_abort", 8'd3, 8'd4, 8'd1, 16'd13);

    // start held high with inputs changing every cycle: accept every W+2 cycles.
    for (int k = 0; k < 30; k++) begin
      ha[k] = W'($urandom); hb[k] = W'($urandom); hc[k] = W'($urandom);
      in1 = ha[k]; in2 = hb[k]; in3 = hc[k]; start = 1'b1;
      tick();
      if (k % (W + 2) == W) begin
        check($sformatf("held.done%0d", k), {31'b0, done}, 1);
        check($sformatf("held.out%0d", k), {16'b0, out},
              {16'b0, ref_mac(ha[k-W], hb[k-W], hc[k-W])});
      end else begin
        check($sformatf("held.nodone%0d", k), {31'b0, done}, 0);
      end
    end
    start = 1'b0;
    repeat (W + 2) tick();

    // Round trip with divider-style operands reconstructs the dividend.
    for (int n = 0; n < 1000; n++) begin
      int unsigned dvd, dvs;
      dvd = $urandom_range(0, 255);
      dvs = $urandom_range(1, 255);
      run_op("roundtrip", W'(dvd / dvs), W'(dvs), W'(dvd % dvs), (2*W)'(dvd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential shift-add multiply-accumulate unit, the inverse of the team's combinational divider. It computes out = in1 × in2 + in3, so a quotient, divisor and remainder reconstruct the original dividend. It processes one multiplier bit per clock, drives a start/busy/done handshake, and sits next to the divider in the arithmetic datapath for self-check and round-trip use.

## Interface
- width, 8, operand width; result is 2×width bits
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; accepted only in IDLE
- in1  input  width  multiplier (quotient)
- in2  input  width  multiplicand (divisor)
- in3  input  width  addend (remainder)
- out  output  2×width  registered result; holds until the next result load
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- ovf  output  1  registered with out; 1 when out[2×width-1:width] != 0, i.e. result does not fit in width bits

## Operation
- States:
  - IDLE: waits for start.
  - RUN: iterates width times.
  - DONE: single cycle, pulses done.
- Transitions:
  - IDLE→RUN on start=1.
  - RUN→DONE when the bit counter equals width-1.
  - DONE→IDLE unconditionally.
- On acceptance, the unit latches in1, in2 and in3 internally. Input changes after acceptance have no effect.
- Accumulator is 2×width bits, initialised to in3 zero-extended.
- RUN iteration i (i = 0..width-1): if in1[i]=1, acc += in2 << i. All arithmetic is unsigned.
- Maximum result is (2^w−1)² + (2^w−1) = 2^2w − 2^w, so no carry out of 2×width bits is possible; no saturation logic.
- out and ovf are updated only on the RUN→DONE edge. They hold through IDLE and the next RUN.
- start is ignored in RUN and DONE; nothing is queued.
- in2=0 or in1=0 is legal: out=in3, full latency, no special flag.

## Timing
- Reset values: out=0, ovf=0, busy=0, done=0, state=IDLE, counter=0, internal operand registers=0.
- rst has priority over start on the same edge.
- rst during RUN or DONE aborts the operation:
  - state returns to IDLE and all outputs clear on that edge;
  - no done pulse for the aborted operation.
- Start accepted at edge T:
  - busy=1 from T until edge T+width;
  - result loaded at edge T+width;
  - done=1 for exactly one cycle, between edges T+width and T+width+1;
  - back in IDLE at T+width+1.
- Latency from acceptance to done is width cycles. With start held high continuously, operations are accepted every width+2 cycles.
- done and busy are never high simultaneously.

## Structure
- Shared package mul_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant, shared with the divider;
  - the counter width $clog2(width).
- One natural sub-module: mul_step, a combinational conditional add of the shifted multiplicand into the accumulator. The top level holds the FSM, counter, operand registers and output registers.

## Test plan
- width=8, start with in1=13, in2=11, in3=5 → done at T+8, out=148, ovf=0, busy high for 8 cycles.
- in1=255, in2=255, in3=255 → out=0xFF00, ovf=1.
- in1=0, in2=200, in3=7 → out=7, ovf=0, still width-cycle latency. Same result for in2=0.
- rst pulsed at the 4th RUN cycle of 13×11+5 → all outputs 0 next cycle, no done. A new start of 3×4+1 → out=13.
- start held high across 3 operations with inputs changing every cycle → accepts every 10 cycles. Each result uses only the inputs sampled at acceptance. start during RUN/DONE is ignored.
- Round trip, 1000 random in1, nonzero in2: q = in1/in2, r = in1 mod in2, fed as in1=q, in2=in2, in3=r → out equals the original dividend, ovf=0.
